// File: rtl/arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : arb_pkg
// Brief   : Shared types, constants and arbitration rule for mem_arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      I_ACC = 2'd1,
      D_ACC = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

   // Width of the per-access wait counter; bounds MAX_WAIT to 1..255.
   localparam int MAX_WAIT_W = 8;

   // Grant rule used both from IDLE and when re-arbitrating on completion:
   // data wins unless it just completed and instruction fetch is waiting.
   function automatic arb_state_t arbitrate(input logic i_req,
                                            input logic d_req,
                                            input logic last_d);
      if (d_req && !(last_d && i_req))
         return D_ACC;
      else if (i_req)
         return I_ACC;
      else
         return IDLE;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : mem_arbiter_if
// Brief   : Datapath-side request ports and RAM-side bus of the arbiter.
//           slave  = arbiter view, master = datapath/RAM environment view.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // instruction fetch port
   logic              i_ren;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_load;
   logic              i_wait;
   // data load/store port
   logic              d_ren;
   logic              d_wen;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_store;
   logic [DATA_W-1:0] d_load;
   logic              d_wait;
   // single-ported RAM
   logic              ram_ren;
   logic              ram_wen;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_store;
   logic [DATA_W-1:0] ram_load;
   logic              ram_ready;

   modport slave (
      input  i_ren, i_addr, d_ren, d_wen, d_addr, d_store, ram_load, ram_ready,
      output i_load, i_wait, d_load, d_wait, ram_ren, ram_wen, ram_addr, ram_store
   );

   modport master (
      output i_ren, i_addr, d_ren, d_wen, d_addr, d_store, ram_load, ram_ready,
      input  i_load, i_wait, d_load, d_wait, ram_ren, ram_wen, ram_addr, ram_store
   );
endinterface

`default_nettype wire

// File: rtl/arb_timeout_ctr.sv
//------------------------------------------------------------------------------
// Module  : arb_timeout_ctr
// Brief   : Per-access RAM wait counter with expiry compare against MAX_WAIT.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_timeout_ctr
   import arb_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic clr,
   input  wire logic inc,
   output logic      expired
);

   logic [MAX_WAIT_W-1:0] wait_cnt;

   // Clear has priority so a finished or abandoned access never leaks counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if (clr)
         wait_cnt <= '0;
      else if (inc)
         wait_cnt <= wait_cnt + MAX_WAIT_W'(1);
   end

   assign expired = (wait_cnt == MAX_WAIT_W'(MAX_WAIT));

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mem_arbiter
// Brief   : Shares one single-ported RAM between instruction fetch and data
//           load/store ports with alternating fairness and access timeout.
//           Optional macro ARB_STATS_EN adds grant and stall counters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  wire logic    clk,
   input  wire logic    rst,
   mem_arbiter_if.slave bus,
   output logic         err
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]  stat_i_grants,
   output logic [31:0]  stat_d_grants,
   output logic [31:0]  stat_stall
`endif
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
   localparam logic [DATA_W-1:0] ZERO_DATA = '0;

   arb_state_t state;
   arb_state_t state_nxt;
   grant_t     granted;
   logic       last_d;
   logic       last_d_nxt;
   logic       err_nxt;

   logic       d_req;
   logic       in_acc;
   logic       live;
   logic       done;
   logic       i_done;
   logic       d_done;
   logic       abort;
   logic       expired;
   logic       timeout;
   logic       keep_counting;

   assign d_req   = bus.d_ren | bus.d_wen;
   assign in_acc  = (state == I_ACC) || (state == D_ACC);
   assign granted = (state == D_ACC) ? GNT_D : GNT_I;

   // The granted request must still be asserted for the access to exist.
   assign live    = ((state == I_ACC) && bus.i_ren) || ((state == D_ACC) && d_req);
   assign done    = live & bus.ram_ready;
   assign i_done  = done & (granted == GNT_I);
   assign d_done  = done & (granted == GNT_D);
   assign abort   = in_acc & ~live;
   assign timeout = live & ~bus.ram_ready & expired;

   assign keep_counting = live & ~bus.ram_ready & ~expired;

   arb_timeout_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (~keep_counting),
      .inc     (keep_counting),
      .expired (expired)
   );

   // State register together with fairness history and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         last_d <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         last_d <= last_d_nxt;
         err    <= err_nxt;
      end
   end

   // Next state: completion re-arbitrates straight into the next access,
   // withdrawal and timeout fall back to IDLE.
   always_comb begin
      state_nxt  = state;
      last_d_nxt = last_d;
      err_nxt    = err;
      case (state)
         IDLE: begin
            state_nxt = arbitrate(bus.i_ren, d_req, last_d);
         end
         I_ACC, D_ACC: begin
            if (done) begin
               last_d_nxt = (granted == GNT_D);
               state_nxt  = arbitrate(bus.i_ren, d_req, last_d_nxt);
            end else if (abort) begin
               state_nxt = IDLE;
            end else if (timeout) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs: RAM driven from the granted port's live inputs; load data
   // and completion only in the ram_ready cycle.
   always_comb begin
      bus.ram_ren   = 1'b0;
      bus.ram_wen   = 1'b0;
      bus.ram_addr  = ZERO_ADDR;
      bus.ram_store = ZERO_DATA;
      if (live) begin
         if (granted == GNT_I) begin
            bus.ram_ren  = 1'b1;
            bus.ram_addr = bus.i_addr;
         end else begin
            bus.ram_addr = bus.d_addr;
            if (bus.d_wen) begin
               bus.ram_wen   = 1'b1;
               bus.ram_store = bus.d_store;
            end else begin
               bus.ram_ren = 1'b1;
            end
         end
      end
      bus.i_load = i_done ? bus.ram_load : ZERO_DATA;
      bus.d_load = (d_done && !bus.d_wen) ? bus.ram_load : ZERO_DATA;
      bus.i_wait = bus.i_ren & ~i_done;
      bus.d_wait = d_req & ~d_done;
   end

`ifdef ARB_STATS_EN
   // Free-running statistics, wrapping naturally at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_i_grants <= '0;
         stat_d_grants <= '0;
         stat_stall    <= '0;
      end else begin
         if (i_done)
            stat_i_grants <= stat_i_grants + 32'd1;
         if (d_done)
            stat_d_grants <= stat_d_grants + 32'd1;
         if (bus.i_wait || bus.d_wait)
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire
